// File: rtl/prbs_pkg.sv
// Shared PRBS definitions for the generator and checker sides.
//   state_e    : checker acquisition state
//   PRBS*_LEN/_TAP : standard polynomial constants (x^LEN + x^TAP + 1)
//   lfsr_fb    : feedback bit of a Fibonacci LFSR held in sr[len-1:0]
//   lfsr_next  : next LFSR value, either loaded from a data bit or free-running
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned PRBS7_TAP  = 6;
    localparam int unsigned PRBS15_LEN = 15;
    localparam int unsigned PRBS15_TAP = 14;

    // Widest LFSR the helper functions handle.
    localparam int unsigned LFSR_MAX_W = 32;

    // Feedback bit: the oldest bit XOR the second tap (taps are 1-based).
    function automatic logic lfsr_fb(
        input logic [LFSR_MAX_W-1:0] sr,
        input int unsigned           len,
        input int unsigned           tap
    );
        return sr[5'(len - 1)] ^ sr[5'(tap - 1)];
    endfunction

    // Shift in either the received bit (load) or the feedback bit, and mask to len bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] sr,
        input int unsigned           len,
        input int unsigned           tap,
        input logic                  load,
        input logic                  din
    );
        logic                  in_bit;
        logic [LFSR_MAX_W-1:0] mask;
        in_bit = load ? din : lfsr_fb(sr, len, tap);
        mask   = (len >= LFSR_MAX_W) ? {LFSR_MAX_W{1'b1}} : ((32'd1 << len) - 32'd1);
        return ((sr << 1) | {{(LFSR_MAX_W-1){1'b0}}, in_bit}) & mask;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with load / free-run select, shared by PRBS generator and checker.
// Ports:
//   clk, r    : clock, synchronous active-high reset (register clears to zero)
//   en_i      : advance the register this cycle
//   load_i    : 1 = shift in din_i, 0 = shift in the polynomial feedback
//   din_i     : data bit shifted in when loading
//   sr_o      : registered LFSR contents, sr_o[LEN-1] is the oldest bit
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int unsigned LEN = PRBS7_LEN,
    parameter int unsigned TAP = PRBS7_TAP
) (
    input  logic           clk,
    input  logic           r,
    input  logic           en_i,
    input  logic           load_i,
    input  logic           din_i,
    output logic [LEN-1:0] sr_o
);

    logic [LEN-1:0] sr_q;
    logic [LEN-1:0] sr_d;

    // Next value; holds when not enabled.
    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d = LEN'(lfsr_next(LFSR_MAX_W'(sr_q), LEN, TAP, load_i, din_i));
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS receiver/checker: self-synchronises a local LFSR to the received
// stream, then counts checked bits and bit errors, dropping lock when too many
// errors land in one window.
// Ports:
//   clk, r     : clock, synchronous active-high reset
//   din        : received serial bit
//   din_vld    : din is valid this cycle; nothing advances otherwise
//   clr_cnt    : synchronous clear of err_cnt / bit_cnt (wins over increment)
//   locked     : checker is in LOCKED state
//   err_pulse  : one-cycle pulse per errored bit while locked (latency 1)
//   err_cnt    : saturating errored-bit count since last clear
//   bit_cnt    : saturating count of bits checked while locked
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned PRBS_LEN = PRBS7_LEN,
    parameter int unsigned TAP_B    = PRBS7_TAP,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned WIN      = 64,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int unsigned FILL_W  = $clog2(PRBS_LEN + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WIN);
    localparam int unsigned WERR_W  = $clog2(LOSS_THR + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e              state_q,     state_d;
    logic [FILL_W-1:0]   fill_q,      fill_d;
    logic [MATCH_W-1:0]  match_q,     match_d;
    logic [WIN_W-1:0]    win_cnt_q,   win_cnt_d;
    logic [WERR_W-1:0]   win_err_q,   win_err_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;

    logic                lfsr_en;
    logic                lfsr_load;
    logic [PRBS_LEN-1:0] sr;
    logic                pred;
    logic                err;
    logic [WERR_W-1:0]   werr_sum;

    // Local LFSR: loads received bits while searching, free-runs once locked.
    prbs_lfsr #(
        .LEN (PRBS_LEN),
        .TAP (TAP_B)
    ) u_lfsr (
        .clk    (clk),
        .r      (r),
        .en_i   (lfsr_en),
        .load_i (lfsr_load),
        .din_i  (din),
        .sr_o   (sr)
    );

    // Predicted next received bit from the current LFSR contents.
    assign pred = lfsr_fb(LFSR_MAX_W'(sr), PRBS_LEN, TAP_B);

    // Acquisition / tracking FSM and counter next-state.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        lfsr_en     = 1'b0;
        lfsr_load   = 1'b0;
        err         = 1'b0;
        werr_sum    = win_err_q;

        if (din_vld) begin
            lfsr_en = 1'b1;
            unique case (state_q)
                SEARCH: begin
                    lfsr_load = 1'b1;
                    // Predictions are meaningless until the LFSR holds PRBS_LEN received bits.
                    if (fill_q != FILL_W'(PRBS_LEN)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (din == pred) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    err         = din ^ pred;
                    err_pulse_d = err;
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (err && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    // win_err_q is always below LOSS_THR, so the sum cannot overflow.
                    werr_sum = win_err_q + WERR_W'(err);
                    if (werr_sum == WERR_W'(LOSS_THR)) begin
                        // Loss of lock: restart acquisition but keep the LFSR contents.
                        state_d   = SEARCH;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_W'(WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = werr_sum;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        // Clear overrides a same-cycle increment.
        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q     <= SEARCH;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: the stimulus process pushes expected output
// values tagged with the cycle they apply to; a monitor pops and compares them
// on the falling edge. A second instance with CNT_W=4 and a high loss threshold
// exercises counter saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        r;
    logic        din;
    logic        din_vld;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_cnt4;
    logic [3:0]  bit_cnt4;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .r         (r),
        .din       (din),
        .din_vld   (din_vld),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    prbs_checker #(
        .CNT_W    (4),
        .LOSS_THR (32)
    ) dut4 (
        .clk       (clk),
        .r         (r),
        .din       (din),
        .din_vld   (din_vld),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4),
        .bit_cnt   (bit_cnt4)
    );

    localparam int S_LOCK   = 0;
    localparam int S_PULSE  = 1;
    localparam int S_ERR    = 2;
    localparam int S_BIT    = 3;
    localparam int S_ERR4   = 4;
    localparam int S_LOCK4  = 5;
    localparam int S_PULSE4 = 6;
    localparam int S_BIT4   = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    string       sbn[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  g;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_LOCK:   return {31'd0, locked};
            S_PULSE:  return {31'd0, err_pulse};
            S_ERR:    return err_cnt;
            S_BIT:    return bit_cnt;
            S_ERR4:   return {28'd0, err_cnt4};
            S_LOCK4:  return {31'd0, locked4};
            S_PULSE4: return {31'd0, err_pulse4};
            S_BIT4:   return {28'd0, bit_cnt4};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_v(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
        sbn.push_back(name);
    endtask

    // One clock of stimulus; valid bits come from a PRBS7 source (x^7+x^6+1).
    task automatic step(input logic inv, input logic vld, input logic clr, input logic rst);
        logic b;
        if (vld) begin
            b   = g[6] ^ g[5];
            g   = {g[5:0], b};
            din = b ^ inv;
        end else begin
            din = 1'($urandom);
        end
        din_vld = vld;
        clr_cnt = clr;
        r       = rst;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        string       nm;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            nm = sbn.pop_front();
            a  = act(e.sel);
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s stale expectation cycle=%0d now=%0d", nm, e.cyc, cyc);
            end else if (a !== e.val) begin
                failures++;
                $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, a, e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        r       = 1'b1;
        din     = 1'b0;
        din_vld = 1'b0;
        clr_cnt = 1'b0;
        g       = 7'h7F;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_v(S_LOCK,  32'd0, "rst_locked");
        exp_v(S_PULSE, 32'd0, "rst_err_pulse");
        exp_v(S_ERR,   32'd0, "rst_err_cnt");
        exp_v(S_BIT,   32'd0, "rst_bit_cnt");

        // Acquisition: lock after 7 fill bits + 16 matches.
        for (int i = 1; i <= 23; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 22) exp_v(S_LOCK, 32'd0, "acq_not_yet_locked");
            if (i == 23) begin
                exp_v(S_LOCK, 32'd1, "acq_locked_bit23");
                exp_v(S_ERR,  32'd0, "acq_err_cnt");
                exp_v(S_BIT,  32'd0, "acq_bit_cnt");
            end
        end
        for (int i = 1; i <= 1000; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 1000) begin
                exp_v(S_BIT,  32'd1000, "clean_bit_cnt");
                exp_v(S_ERR,  32'd0,    "clean_err_cnt");
                exp_v(S_LOCK, 32'd1,    "clean_locked");
            end
        end

        // Single-bit error on bit 100.
        for (int i = 1; i <= 101; i++) begin
            step(i == 100, 1'b1, 1'b0, 1'b0);
            if (i == 99) exp_v(S_PULSE, 32'd0, "single_no_pulse_before");
            if (i == 100) begin
                exp_v(S_PULSE, 32'd1, "single_pulse");
                exp_v(S_ERR,   32'd1, "single_err_cnt");
                exp_v(S_LOCK,  32'd1, "single_still_locked");
            end
            if (i == 101) begin
                exp_v(S_PULSE, 32'd0,    "single_pulse_one_cycle");
                exp_v(S_BIT,   32'd1101, "single_bit_cnt");
                exp_v(S_ERR4,  32'd1,    "single_err_cnt4");
            end
        end

        // Pad to the next window boundary, clearing counters on the last bit.
        for (int i = 1; i <= 51; i++) begin
            step(1'b0, 1'b1, i == 51, 1'b0);
            if (i == 51) begin
                exp_v(S_ERR,  32'd0, "pad_clr_err_cnt");
                exp_v(S_BIT,  32'd0, "pad_clr_bit_cnt");
                exp_v(S_LOCK, 32'd1, "pad_locked");
            end
        end

        // Loss of lock: 8 errors within one window (every third bit).
        for (int j = 0; j <= 21; j++) begin
            step((j % 3) == 0, 1'b1, 1'b0, 1'b0);
            if (j == 20) begin
                exp_v(S_LOCK, 32'd1, "loss_locked_after_7");
                exp_v(S_ERR,  32'd7, "loss_err_cnt_7");
            end
            if (j == 21) begin
                exp_v(S_LOCK,   32'd0,  "loss_unlocked_after_8");
                exp_v(S_ERR,    32'd8,  "loss_err_cnt_8");
                exp_v(S_BIT,    32'd22, "loss_bit_cnt");
                exp_v(S_PULSE,  32'd1,  "loss_pulse");
                exp_v(S_LOCK4,  32'd1,  "loss_dut4_locked");
                exp_v(S_ERR4,   32'd8,  "loss_err_cnt4");
                exp_v(S_PULSE4, 32'd1,  "loss_pulse4");
            end
        end
        for (int i = 1; i <= 23; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 1)  exp_v(S_PULSE, 32'd0, "relock_no_pulse_search");
            if (i == 22) exp_v(S_LOCK,  32'd0, "relock_not_yet");
            if (i == 23) begin
                exp_v(S_LOCK, 32'd1,  "relock_locked");
                exp_v(S_ERR,  32'd8,  "relock_err_cnt_kept");
                exp_v(S_BIT,  32'd22, "relock_bit_cnt_kept");
            end
        end

        // Clear on the same cycle as an errored bit.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        exp_v(S_ERR,   32'd0, "clr_vs_inc_err_cnt");
        exp_v(S_BIT,   32'd0, "clr_vs_inc_bit_cnt");
        exp_v(S_PULSE, 32'd1, "clr_vs_inc_pulse");
        exp_v(S_ERR4,  32'd0, "clr_vs_inc_err_cnt4");
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp_v(S_BIT,   32'd1, "after_clr_bit_cnt");
        exp_v(S_ERR,   32'd0, "after_clr_err_cnt");
        exp_v(S_PULSE, 32'd0, "after_clr_pulse");

        // Reset while locked.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        exp_v(S_LOCK,  32'd0, "midrst_locked");
        exp_v(S_PULSE, 32'd0, "midrst_pulse");
        exp_v(S_ERR,   32'd0, "midrst_err_cnt");
        exp_v(S_BIT,   32'd0, "midrst_bit_cnt");
        exp_v(S_LOCK4, 32'd0, "midrst_locked4");
        exp_v(S_BIT4,  32'd0, "midrst_bit_cnt4");

        // Gapped re-acquisition: valid every other cycle, garbage in between.
        for (int i = 1; i <= 23; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 23) exp_v(S_LOCK, 32'd1, "gap_locked_bit23");
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 22) exp_v(S_LOCK, 32'd0, "gap_not_yet_locked");
            if (i == 23) begin
                exp_v(S_LOCK, 32'd1, "gap_locked_hold");
                exp_v(S_BIT,  32'd0, "gap_bit_cnt_acq");
                exp_v(S_ERR,  32'd0, "gap_err_cnt_acq");
            end
        end
        for (int i = 1; i <= 10; i++) begin
            step(i == 5, 1'b1, 1'b0, 1'b0);
            if (i == 5) exp_v(S_PULSE, 32'd1, "gap_err_pulse");
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 5) begin
                exp_v(S_PULSE, 32'd0, "gap_pulse_invalid_cycle");
                exp_v(S_ERR,   32'd1, "gap_err_cnt_hold");
            end
        end
        exp_v(S_BIT,  32'd10, "gap_bit_cnt_valid_only");
        exp_v(S_ERR,  32'd1,  "gap_err_cnt");
        exp_v(S_ERR4, 32'd1,  "gap_err_cnt4");

        // 20 errors every fourth bit: main instance drops lock, CNT_W=4 saturates.
        for (int j = 0; j <= 79; j++) begin
            step((j % 4) == 0, 1'b1, 1'b0, 1'b0);
            if (j == 23) begin
                exp_v(S_LOCK, 32'd1, "sat_main_locked");
                exp_v(S_ERR,  32'd7, "sat_main_err_7");
            end
            if (j == 24) begin
                exp_v(S_LOCK, 32'd0, "sat_main_unlocked");
                exp_v(S_ERR,  32'd8, "sat_main_err_8");
            end
            if (j == 51) exp_v(S_ERR4, 32'd14, "sat_err_cnt4_14");
            if (j == 79) begin
                exp_v(S_ERR4,  32'd15, "sat_err_cnt4_15");
                exp_v(S_LOCK4, 32'd1,  "sat_dut4_locked");
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
